// File: rtl/nonce_issuer.sv
// Head-end nonce source: loads a start word and count, issues one m04 word
// per cycle, halts on found, and pulses exhausted after the pipe drains.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   valid      new-work strobe, samples workM04/workCnt
//   found      nonce-found strobe from the pipe tail
//   stall      suppress issue this cycle
//   workM04    starting m04 word (64)
//   workCnt    number of words to issue (32)
//   vldOut     valid to first pipe stage
//   m04Out     m04 word to first pipe stage (64)
//   busy       high while running or draining
//   exhausted  one-cycle pulse: range issued and drained, no find
//   issued     words issued since last valid (32, saturating)
module nonce_issuer #(
  parameter logic [63:0] STEP       = 64'd1,
  parameter int unsigned PIPE_DEPTH = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        found,
  input  logic        stall,
  input  logic [63:0] workM04,
  input  logic [31:0] workCnt,
  output logic        vldOut,
  output logic [63:0] m04Out,
  output logic        busy,
  output logic        exhausted,
  output logic [31:0] issued
);

  localparam logic [31:0] DRAIN_INIT = 32'(PIPE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [63:0] r_nonce;
  logic [31:0] r_remaining;
  logic [31:0] r_drain;
  logic        r_vld;
  logic [63:0] r_m04;
  logic        r_busy;
  logic        r_exh;
  logic [31:0] r_issued;

  logic w_active;
  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_nonce     <= '0;
      r_remaining <= '0;
      r_drain     <= '0;
      r_vld       <= 1'b0;
      r_m04       <= '0;
      r_busy      <= 1'b0;
      r_exh       <= 1'b0;
      r_issued    <= '0;
    end else begin
      r_exh <= 1'b0;
      if (valid) begin
        // new work wins over everything, including a same-cycle found
        r_nonce     <= workM04;
        r_remaining <= workCnt;
        r_issued    <= '0;
        r_vld       <= 1'b0;
        if (workCnt == 32'd0) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_exh   <= 1'b1;
        end else begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end
      end else if (found && w_active) begin
        r_state <= S_HALT;
        r_vld   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_RUN: begin
            if (!stall) begin
              r_vld       <= 1'b1;
              r_m04       <= r_nonce;
              r_nonce     <= r_nonce + STEP;
              r_remaining <= r_remaining - 32'd1;
              if (r_issued != '1) begin
                r_issued <= r_issued + 32'd1;
              end
              if (r_remaining == 32'd1) begin
                r_state <= S_DRAIN;
                r_drain <= DRAIN_INIT;
              end
            end else begin
              r_vld <= 1'b0;
            end
          end
          S_DRAIN: begin
            // drain ignores stall: in-flight words leave regardless
            r_vld <= 1'b0;
            if (r_drain == 32'd0) begin
              r_exh   <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_drain <= r_drain - 32'd1;
            end
          end
          default: begin
            r_vld <= 1'b0;
          end
        endcase
      end
    end
  end

  assign vldOut    = r_vld;
  assign m04Out    = r_m04;
  assign busy      = r_busy;
  assign exhausted = r_exh;
  assign issued    = r_issued;

endmodule

// File: tb/tb_nonce_issuer.sv
// Bench for nonce_issuer: two instances (STEP=1/DEPTH=3, STEP=2/DEPTH=0)
// share stimulus and are checked every cycle against a behavioural model.
module tb_nonce_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        found = 1'b0;
  logic        stall = 1'b0;
  logic [63:0] workM04 = '0;
  logic [31:0] workCnt = '0;

  logic        vo [2];
  logic [63:0] mo [2];
  logic        bo [2];
  logic        eo [2];
  logic [31:0] io [2];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nonce_issuer #(.STEP(64'd1), .PIPE_DEPTH(3)) u_dut1 (
    .clk(clk), .rst(rst), .valid(valid), .found(found), .stall(stall),
    .workM04(workM04), .workCnt(workCnt),
    .vldOut(vo[0]), .m04Out(mo[0]), .busy(bo[0]),
    .exhausted(eo[0]), .issued(io[0])
  );

  nonce_issuer #(.STEP(64'd2), .PIPE_DEPTH(0)) u_dut2 (
    .clk(clk), .rst(rst), .valid(valid), .found(found), .stall(stall),
    .workM04(workM04), .workCnt(workCnt),
    .vldOut(vo[1]), .m04Out(mo[1]), .busy(bo[1]),
    .exhausted(eo[1]), .issued(io[1])
  );

  function automatic logic [63:0] stepv(int d);
    return (d == 0) ? 64'd1 : 64'd2;
  endfunction

  function automatic longint depth(int d);
    return (d == 0) ? 3 : 0;
  endfunction

  task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h",
               nm, d, $time, act, exp);
    end
  endtask

  // Behavioural model: words are base + STEP*k, drain end is an absolute
  // edge number computed when the last word goes out.
  localparam int P_IDLE = 0;
  localparam int P_RUN = 1;
  localparam int P_DRAIN = 2;
  localparam int P_HALT = 3;

  int          ph [2];
  logic [63:0] base [2];
  longint      total [2];
  longint      nw [2];
  longint      exh_at [2];
  logic        e_vld [2];
  logic [63:0] e_m04 [2];
  logic        e_exh [2];
  longint      cyc = 0;

  task automatic mstep(int d);
    e_exh[d] = 1'b0;
    e_vld[d] = 1'b0;
    if (valid) begin
      base[d] = workM04;
      total[d] = longint'(workCnt);
      nw[d] = 0;
      if (workCnt == 0) begin
        ph[d] = P_IDLE;
        e_exh[d] = 1'b1;
      end else begin
        ph[d] = P_RUN;
      end
    end else if (found && (ph[d] == P_RUN || ph[d] == P_DRAIN)) begin
      ph[d] = P_HALT;
    end else if (ph[d] == P_RUN && !stall) begin
      e_vld[d] = 1'b1;
      e_m04[d] = base[d] + stepv(d) * 64'(nw[d]);
      nw[d]++;
      if (nw[d] == total[d]) begin
        ph[d] = P_DRAIN;
        exh_at[d] = cyc + 1 + depth(d);
      end
    end else if (ph[d] == P_DRAIN && cyc == exh_at[d]) begin
      e_exh[d] = 1'b1;
      ph[d] = P_IDLE;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        ph[d] = P_IDLE;
        base[d] = '0;
        total[d] = 0;
        nw[d] = 0;
        exh_at[d] = 0;
        e_vld[d] = 1'b0;
        e_m04[d] = '0;
        e_exh[d] = 1'b0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) mstep(d);
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [31:0] e_iss;
      e_iss = (nw[d] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(nw[d]);
      chk("vldOut", d, 64'(vo[d]), 64'(e_vld[d]));
      chk("m04Out", d, mo[d], e_m04[d]);
      chk("busy", d, 64'(bo[d]),
          64'(ph[d] == P_RUN || ph[d] == P_DRAIN));
      chk("exhausted", d, 64'(eo[d]), 64'(e_exh[d]));
      chk("issued", d, 64'(io[d]), 64'(e_iss));
    end
  end

  task automatic drv(logic v, logic f, logic s,
                     logic [63:0] m, logic [31:0] c);
    valid = v;
    found = f;
    stall = s;
    workM04 = m;
    workCnt = c;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [63:0] exp1 [8];
    idle();
    tick(3);
    for (int d = 0; d < 2; d++) begin
      chk("rst_vld", d, 64'(vo[d]), 64'd0);
      chk("rst_m04", d, mo[d], 64'd0);
      chk("rst_busy", d, 64'(bo[d]), 64'd0);
      chk("rst_iss", d, 64'(io[d]), 64'd0);
    end
    rst = 1'b0;
    tick(2);

    // basic run: 0x10, count 4
    drv(1'b1, 1'b0, 1'b0, 64'h10, 32'd4);
    tick();
    idle();
    chk("b_busy0", 0, 64'(bo[0]), 64'd1);
    chk("b_vld0", 0, 64'(vo[0]), 64'd0);
    exp1 = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h13, 64'h13, 64'h13, 64'h13};
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("b_m04", 0, mo[0], exp1[i]);
      chk("b_vld", 0, 64'(vo[0]), 64'(i < 4));
      chk("b_exh", 0, 64'(eo[0]), 64'(i == 7));
      chk("b_busy", 0, 64'(bo[0]), 64'(i < 7));
      chk("b_exh2", 1, 64'(eo[1]), 64'(i == 4));
    end
    chk("b_iss", 0, 64'(io[0]), 64'd4);
    chk("b_m04_s2", 1, mo[1], 64'h16);
    tick(2);

    // stall for two cycles after first issue
    drv(1'b1, 1'b0, 1'b0, 64'h10, 32'd3);
    tick();
    idle();
    tick();
    chk("s_m0", 0, mo[0], 64'h10);
    stall = 1'b1;
    tick();
    chk("s_gap1", 0, 64'(vo[0]), 64'd0);
    tick();
    chk("s_gap2", 0, 64'(vo[0]), 64'd0);
    chk("s_hold", 0, mo[0], 64'h10);
    stall = 1'b0;
    tick();
    chk("s_m1", 0, mo[0], 64'h11);
    tick();
    chk("s_m2", 0, mo[0], 64'h12);
    chk("s_iss", 0, 64'(io[0]), 64'd3);
    tick(6);

    // found after the 5th issue
    drv(1'b1, 1'b0, 1'b0, 64'h100, 32'd100);
    tick();
    idle();
    tick(5);
    chk("f_m5", 0, mo[0], 64'h104);
    found = 1'b1;
    tick();
    found = 1'b0;
    chk("f_vld", 0, 64'(vo[0]), 64'd0);
    chk("f_iss", 0, 64'(io[0]), 64'd5);
    chk("f_busy", 0, 64'(bo[0]), 64'd0);
    tick(10);
    drv(1'b1, 1'b0, 1'b0, 64'h200, 32'd2);
    tick();
    idle();
    tick();
    chk("f_restart", 0, mo[0], 64'h200);
    tick(6);

    // valid + found together mid-run
    drv(1'b1, 1'b0, 1'b0, 64'h300, 32'd50);
    tick();
    idle();
    tick(3);
    drv(1'b1, 1'b1, 1'b0, 64'h500, 32'd2);
    tick();
    idle();
    chk("vf_vld", 0, 64'(vo[0]), 64'd0);
    chk("vf_busy", 0, 64'(bo[0]), 64'd1);
    tick();
    chk("vf_m04", 0, mo[0], 64'h500);
    chk("vf_vld1", 0, 64'(vo[0]), 64'd1);
    tick(8);

    // zero count
    drv(1'b1, 1'b0, 1'b0, 64'h777, 32'd0);
    tick();
    idle();
    chk("z_exh", 0, 64'(eo[0]), 64'd1);
    chk("z_exh2", 1, 64'(eo[1]), 64'd1);
    chk("z_vld", 0, 64'(vo[0]), 64'd0);
    tick(3);

    // wrap
    drv(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 32'd3);
    tick();
    idle();
    tick();
    chk("w_m0", 1, mo[1], 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("w_m1", 1, mo[1], 64'h0);
    chk("w_m1s1", 0, mo[0], 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("w_m2", 1, mo[1], 64'h2);
    chk("w_m2s1", 0, mo[0], 64'h0);
    tick(6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] m;
      m = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) m[63:8] = '1;
      drv($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 25, m, 32'($urandom_range(0, 10)));
      tick();
    end
    idle();
    tick(6);

    // asynchronous reset mid-run
    drv(1'b1, 1'b0, 1'b0, 64'h900, 32'd20);
    tick();
    idle();
    tick(3);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("ar_vld", d, 64'(vo[d]), 64'd0);
      chk("ar_m04", d, mo[d], 64'd0);
      chk("ar_busy", d, 64'(bo[d]), 64'd0);
      chk("ar_exh", d, 64'(eo[d]), 64'd0);
      chk("ar_iss", d, 64'(io[d]), 64'd0);
    end
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("ar_idle", 0, 64'(vo[0]), 64'd0);
    chk("ar_idleb", 0, 64'(bo[0]), 64'd0);
    drv(1'b1, 1'b0, 1'b0, 64'hA, 32'd1);
    tick();
    idle();
    tick();
    chk("ar_new", 0, mo[0], 64'hA);
    tick(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
